// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline load/flush sequencer: merges cache wait states, load-use hazards and
// taken control transfers into per-stage strobes, and keeps stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  output logic             imem_read,
  output logic             dmem_en,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Cache handshake: a request (imem_read / dmem_en) stays high until the
  // matching *_resp pulse; a response seen while frozen is remembered in a
  // done flag so the request is dropped rather than re-issued.
  logic imem_done;
  logic dmem_done;
  logic imem_wait;
  logic dmem_wait;
  logic advance;
  logic lu_hazard;
  logic br_act;

  always_comb begin
    imem_wait = ~imem_done & ~imem_resp;
    dmem_wait = dmem_req & ~dmem_done & ~dmem_resp;
    advance   = ~imem_wait & ~dmem_wait;
    lu_hazard = ex_mem_read & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr));
    br_act    = ~rst & advance & ex_br_taken;
  end

  always_comb begin
    imem_read   = ~rst & ~imem_done;
    dmem_en     = ~rst & dmem_req & ~dmem_done;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst && advance) begin
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (ex_br_taken) begin
        // Redirect: squash the two younger instructions.
        load_pc     = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (lu_hazard) begin
        // Hold PC and IF/ID, insert a bubble behind the load.
        flush_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
        load_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (advance) begin
        imem_done <= 1'b0;
        dmem_done <= 1'b0;
      end else begin
        imem_done <= imem_done | imem_resp;
        dmem_done <= dmem_done | dmem_resp;
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (br_act) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a priority-rule model checked every
// cycle, plus literal expectations for each scenario.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_resp = 1'b0;
  logic             dmem_req = 1'b0;
  logic             dmem_resp = 1'b0;
  logic [4:0]       id_rs1_addr = 5'd0;
  logic [4:0]       id_rs2_addr = 5'd0;
  logic [4:0]       ex_rd = 5'd0;
  logic             ex_mem_read = 1'b0;
  logic             ex_br_taken = 1'b0;
  logic             imem_read, dmem_en, load_pc, load_if_id, load_id_ex;
  logic             load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // {imem_read, dmem_en, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [8:0] V_NORM   = 9'b101111100;
  localparam logic [8:0] V_LU     = 9'b100001101;
  localparam logic [8:0] V_BR     = 9'b101001111;
  localparam logic [8:0] V_FRZ_I  = 9'b100000000;

  logic [8:0] dut_vec;
  assign dut_vec = {imem_read, dmem_en, load_pc, load_if_id, load_id_ex,
                    load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .dmem_en(dmem_en), .load_pc(load_pc),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic             m_imem_got = 1'b0;
  logic             m_dmem_got = 1'b0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  typedef enum int {A_RESET, A_FREEZE, A_BRANCH, A_LOADUSE, A_NORMAL} action_t;

  function automatic action_t model_action();
    bit fetch_pending, data_pending, hazard;
    fetch_pending = !m_imem_got && !imem_resp;
    data_pending  = dmem_req && !m_dmem_got && !dmem_resp;
    hazard = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1_addr || ex_rd == id_rs2_addr);
    if (rst)                           return A_RESET;
    if (fetch_pending || data_pending) return A_FREEZE;
    if (ex_br_taken)                   return A_BRANCH;
    if (hazard)                        return A_LOADUSE;
    return A_NORMAL;
  endfunction

  function automatic logic [8:0] model_vec();
    logic ir, de;
    action_t a;
    a  = model_action();
    ir = !rst && !m_imem_got;
    de = !rst && dmem_req && !m_dmem_got;
    case (a)
      A_RESET:   return 9'b0;
      A_FREEZE:  return {ir, de, 7'b0000000};
      A_BRANCH:  return {ir, de, 7'b1001111};
      A_LOADUSE: return {ir, de, 7'b0001101};
      default:   return {ir, de, 7'b1111100};
    endcase
  endfunction

  always @(posedge clk) begin
    action_t a;
    a = model_action();
    if (a == A_RESET) begin
      m_imem_got <= 1'b0;
      m_dmem_got <= 1'b0;
      m_stall    <= '0;
      m_flush    <= '0;
    end else if (a == A_FREEZE) begin
      m_imem_got <= m_imem_got || imem_resp;
      m_dmem_got <= m_dmem_got || dmem_resp;
      m_stall    <= m_stall + 1;
    end else begin
      m_imem_got <= 1'b0;
      m_dmem_got <= 1'b0;
      if (a == A_BRANCH) m_flush <= m_flush + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_vec", {23'd0, dut_vec}, {23'd0, model_vec()});
      chk("model_stall_cnt", stall_cnt, m_stall);
      chk("model_flush_cnt", flush_cnt, m_flush);
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input logic r, input logic ir, input logic dq, input logic dr,
                      input logic br, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    rst = r; imem_resp = ir; dmem_req = dq; dmem_resp = dr;
    ex_br_taken = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1_addr = rs1; id_rs2_addr = rs2;
    @(negedge clk);
  endtask

  task automatic idle_ok();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
  endtask

  initial begin
    // reset for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk_en = 1'b1;
      chk("reset_outputs", {23'd0, dut_vec}, 32'd0);
    end
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);

    idle_ok();
    chk("first_normal", {23'd0, dut_vec}, {23'd0, V_NORM});

    // load-use: rd=5 matches rs2
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5);
    chk("load_use", {23'd0, dut_vec}, {23'd0, V_LU});
    // rd=0 never hazards
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("load_use_rd0", {23'd0, dut_vec}, {23'd0, V_NORM});

    // branch wins over load-use
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd3);
    chk("branch_over_lu", {23'd0, dut_vec}, {23'd0, V_BR});
    idle_ok();
    chk("flush_cnt_1", flush_cnt, 32'd1);

    // imem_resp low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
      chk("imem_freeze", {23'd0, dut_vec}, {23'd0, V_FRZ_I});
    end
    idle_ok();
    chk("imem_advance", {23'd0, dut_vec}, {23'd0, V_NORM});
    chk("stall_cnt_3", stall_cnt, 32'd3);

    // dmem access: imem_resp at c0, dmem_resp at c4
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dm_c0", {23'd0, dut_vec}, 32'h180);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
      chk("dm_hold", {23'd0, dut_vec}, 32'h080);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dm_c4_advance", {23'd0, dut_vec}, 32'h0FC);
    idle_ok();
    chk("dm_c5_imem_read", {31'd0, imem_read}, 32'd1);
    chk("stall_cnt_7", stall_cnt, 32'd7);

    // dmem_resp at c1 while imem waits until c3
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dd_c0_dmem_en", {31'd0, dmem_en}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dd_c1_dmem_en", {31'd0, dmem_en}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dd_c2", {23'd0, dut_vec}, {23'd0, V_FRZ_I});
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("dd_c3_advance", {23'd0, dut_vec}, {23'd0, V_NORM});
    chk("stall_cnt_10", stall_cnt, 32'd10);

    // simultaneous responses: advance, no flag left set
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("simul_advance", {23'd0, dut_vec}, 32'h1FC);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("simul_no_flags", {23'd0, dut_vec}, 32'h180);

    // reset mid-wait
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("rst_mid_wait", {23'd0, dut_vec}, 32'd0);
    idle_ok();
    chk("post_rst_imem_read", {31'd0, imem_read}, 32'd1);
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", flush_cnt, 32'd0);
    idle_ok();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
